// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S line-in receiver.
// Holds the frame-tracking state encoding and the bit-counter width.
package i2s_pkg;

    localparam int   I2S_CNT_W = 6;
    localparam logic I2S_LEFT  = 1'b0;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        LEFT,
        RIGHT
    } i2s_state_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// Multi-flop synchronizer for one asynchronous codec input.
// With EDGE_DETECT set, it also produces a registered one-cycle rising-edge strobe.
module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_DETECT = 1'b0
) (
    input  logic clk_100,
    input  logic reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;

    // NOTE: non-blocking assignments, so each stage takes the previous stage's old value.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

    generate
        if (EDGE_DETECT) begin : g_rise
            logic r_prev;
            logic r_rise;

            always_ff @(posedge clk_100 or posedge reset) begin
                if (reset) begin
                    r_prev <= 1'b0;
                    r_rise <= 1'b0;
                end else begin
                    r_prev <= o_q;
                    r_rise <= o_q & ~r_prev;
                end
            end

            assign o_rise = r_rise;
        end else begin : g_no_rise
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_line_in_rx.sv
// I2S ADC-path deserializer: turns codec serial line-in data into paired
// left/right SAMPLE_BITS words with a new_sample strobe, all in the clk_100 domain.
module i2s_line_in_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_100,
    input  logic                   reset,
    input  logic                   i2s_bclk,
    input  logic                   i2s_lr,
    input  logic                   i2s_sdata,
    output logic [SAMPLE_BITS-1:0] line_in_l,
    output logic [SAMPLE_BITS-1:0] line_in_r,
    output logic                   new_sample,
    output logic                   frame_err
);

    localparam logic [I2S_CNT_W-1:0] L_SB = I2S_CNT_W'(SAMPLE_BITS);

    logic w_bclk_s;
    logic w_bclk_rise;
    logic w_lr_s;
    logic w_sdata_s;
    logic w_lr_rise_unused;
    logic w_sdata_rise_unused;

    i2s_state_t             r_state;
    logic                   r_lr_prev;
    logic [I2S_CNT_W-1:0]   r_bit_cnt;
    logic [SAMPLE_BITS-1:0] r_shreg;
    logic [SAMPLE_BITS-1:0] r_hold_l;

    logic [SAMPLE_BITS-1:0] w_word;
    logic                   w_short;

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_bclk_sync (
        .clk_100 (clk_100),
        .reset   (reset),
        .i_d     (i2s_bclk),
        .o_q     (w_bclk_s),
        .o_rise  (w_bclk_rise)
    );

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_lr_sync (
        .clk_100 (clk_100),
        .reset   (reset),
        .i_d     (i2s_lr),
        .o_q     (w_lr_s),
        .o_rise  (w_lr_rise_unused)
    );

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_sdata_sync (
        .clk_100 (clk_100),
        .reset   (reset),
        .i_d     (i2s_sdata),
        .o_q     (w_sdata_s),
        .o_rise  (w_sdata_rise_unused)
    );

    // Short words are left-justified so the received bits stay in the MSBs.
    // NOTE: every output gets a default first, so no latch is inferred.
    always_comb begin
        w_short = (r_bit_cnt < L_SB);
        w_word  = r_shreg;
        if (w_short) begin
            w_word = r_shreg << (L_SB - r_bit_cnt);
        end
    end

    // NOTE: data registers are reset as well, so the outputs read 0 right after reset.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            r_state    <= WAIT_SYNC;
            r_lr_prev  <= 1'b0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_hold_l   <= '0;
            line_in_l  <= '0;
            line_in_r  <= '0;
            new_sample <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            new_sample <= 1'b0;
            frame_err  <= 1'b0;
            if (w_bclk_rise) begin
                r_lr_prev <= w_lr_s;
                if (w_lr_s != r_lr_prev) begin
                    r_bit_cnt <= '0;
                    r_shreg   <= '0;
                    case (r_state)
                        WAIT_SYNC: begin
                            if (w_lr_s == I2S_LEFT) r_state <= LEFT;
                        end
                        LEFT: begin
                            r_hold_l  <= w_word;
                            frame_err <= w_short;
                            r_state   <= RIGHT;
                        end
                        RIGHT: begin
                            // The right word goes straight out alongside the held left word.
                            line_in_l  <= r_hold_l;
                            line_in_r  <= w_word;
                            new_sample <= 1'b1;
                            frame_err  <= w_short;
                            r_state    <= LEFT;
                        end
                        default: r_state <= WAIT_SYNC;
                    endcase
                end else if (r_bit_cnt < L_SB) begin
                    r_shreg   <= {r_shreg[SAMPLE_BITS-2:0], w_sdata_s};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end else if (r_bit_cnt != '1) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    logic w_bclk_s_unused;
    assign w_bclk_s_unused = w_bclk_s;

endmodule
